hack_key_input: RTL

//  Memory-mapped input peripheral for the Hack computer on the DE0 board: the read-side

---
 rtl/hack_key_input.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hack_key_input.sv
// Hack memory-mapped input peripheral: synchronised, debounced DE0 buttons become
// acknowledged key codes at the keyboard address; slide switches read back at a second address.
module hack_key_input #(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [14:0] KBD_ADDR        = 15'h6000,
  parameter logic [14:0] SW_ADDR         = 15'h6001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  btn,
  input  logic [9:0]  sw,
  input  logic [14:0] addressM,
  input  logic        writeM,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        pending,
  output logic [1:0]  o_state
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [15:0] CODE_LEFT    = 16'd130;
  localparam logic [15:0] CODE_RIGHT   = 16'd132;
  localparam logic [15:0] CODE_NEWLINE = 16'd128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    WAIT_ACK = 2'd2,
    ACKED    = 2'd3
  } state_t;

  // Buttons are active-low, so "released" is logic 1 everywhere below.
  logic [2:0]    r_btn_meta;
  logic [2:0]    r_btn_sync;
  logic [9:0]    r_sw_meta;
  logic [9:0]    r_sw_sync;
  logic [2:0]    r_btn_deb;
  logic [CW-1:0] r_cnt [3];
  state_t        r_state;
  logic [15:0]   r_key;
  logic          r_pending;

  logic [2:0]    w_deb_next;
  logic [2:0]    w_pressed;
  logic          w_any;
  logic          w_ack;
  logic [15:0]   w_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_meta <= 3'b111;
      r_btn_sync <= 3'b111;
      r_sw_meta  <= 10'd0;
      r_sw_sync  <= 10'd0;
    end else begin
      r_btn_meta <= btn;
      r_btn_sync <= r_btn_meta;
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
    end
  end

  // The FSM reacts to the debounced value being loaded this edge, so a key
  // appears on the same edge the debouncer accepts the press.
  always_comb begin
    w_deb_next = r_btn_deb;
    for (int i = 0; i < 3; i++) begin
      if ((r_btn_sync[i] != r_btn_deb[i]) && (r_cnt[i] == CNT_MAX)) begin
        w_deb_next[i] = r_btn_sync[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_deb <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_btn_deb <= w_deb_next;
      for (int i = 0; i < 3; i++) begin
        if (r_btn_sync[i] != r_btn_deb[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_pressed = ~w_deb_next;
  assign w_any     = |w_pressed;
  assign w_ack     = writeM && (addressM == KBD_ADDR);

  always_comb begin
    w_code = 16'd0;
    if (w_pressed[0]) begin
      w_code = CODE_LEFT;
    end else if (w_pressed[1]) begin
      w_code = CODE_RIGHT;
    end else if (w_pressed[2]) begin
      w_code = CODE_NEWLINE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_key     <= 16'd0;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= HELD;
            r_key     <= w_code;
            r_pending <= 1'b1;
          end
        end
        HELD: begin
          if (w_ack) begin
            r_key     <= 16'd0;
            r_pending <= 1'b0;
            r_state   <= w_any ? ACKED : IDLE;
          end else if (!w_any) begin
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (w_ack) begin
            r_state   <= IDLE;
            r_key     <= 16'd0;
            r_pending <= 1'b0;
          end
        end
        ACKED: begin
          // Wait for full release so one physical press yields one event.
          if (!w_any) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_key     <= 16'd0;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = 16'd0;
    hit   = 1'b0;
    if (addressM == KBD_ADDR) begin
      rdata = r_key;
      hit   = 1'b1;
    end else if (addressM == SW_ADDR) begin
      rdata = {6'b0, r_sw_sync};
      hit   = 1'b1;
    end
  end

  assign pending = r_pending;
  assign o_state = r_state;

endmodule
